// File: rtl/display_pkg.sv
// Shared display types and constants: conversion FSM states, active-low
// seven-segment patterns and the double-dabble adjust constants.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Active-low gfedcba patterns
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // A nibble at or above the threshold is corrected before each shift
    localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADD3_INC    = 4'd3;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment pattern.
// Non-decimal nibbles and an asserted blank input both produce an unlit digit.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/count_bcd_decoder.sv
// Captures a clamped binary count on load, converts it to BCD with one
// double-dabble shift per clock and registers BCD plus seven-segment outputs.
module count_bcd_decoder
    import display_pkg::*;
#(
    parameter int BIN_W    = 16,
    parameter int DIGITS   = 4,
    parameter int MAX_VAL  = 9999,
    parameter int BLANK_LZ = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      value_in,
    input  logic                  load,
    output logic                  ready,
    output logic                  busy,
    output logic                  valid,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SEG_W = 7 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state_reg, state_next;
    logic [BIN_W-1:0]   shift_reg, shift_next;
    logic [BCD_W-1:0]   scratch_reg, scratch_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               ovf_flag_reg, ovf_flag_next;

    logic [BCD_W-1:0]   bcd_reg;
    logic [SEG_W-1:0]   seg_reg;
    logic               ovf_reg;
    logic               valid_reg;

    logic               over_limit;
    logic [BIN_W-1:0]   clamped;
    logic [BCD_W-1:0]   scratch_adj;
    logic [BCD_W-1:0]   scratch_shl;
    logic [BIN_W-1:0]   shift_shl;
    logic [DIGITS-1:0]  digit_zero;
    logic [DIGITS-1:0]  blank_dec;
    logic [SEG_W-1:0]   seg_dec;
    logic [SEG_W-1:0]   seg_rst;

    assign over_limit = value_in > BIN_W'(MAX_VAL);
    assign clamped    = over_limit ? BIN_W'(MAX_VAL) : value_in;

    // Per-digit add-3 correction, zero detect, blanking and decode
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign scratch_adj[4*gi +: 4] =
                (scratch_reg[4*gi +: 4] >= BCD_ADD3_THRESH) ?
                (scratch_reg[4*gi +: 4] + BCD_ADD3_INC) : scratch_reg[4*gi +: 4];

            assign digit_zero[gi] = (scratch_reg[4*gi +: 4] == 4'd0);

            // Units digit always shows, so a zero count reads "0" not blank
            if (gi == 0) begin : g_units
                assign blank_dec[gi]       = 1'b0;
                assign seg_rst[7*gi +: 7]  = SEG_0;
            end else begin : g_upper
                assign blank_dec[gi]       = (BLANK_LZ != 0) && (&digit_zero[DIGITS-1:gi]);
                assign seg_rst[7*gi +: 7]  = (BLANK_LZ != 0) ? SEG_BLANK : SEG_0;
            end

            seg7_decoder u_seg7 (
                .bcd   (scratch_reg[4*gi +: 4]),
                .blank (blank_dec[gi]),
                .seg   (seg_dec[7*gi +: 7])
            );
        end
    endgenerate

    assign scratch_shl = {scratch_adj[BCD_W-2:0], shift_reg[BIN_W-1]};
    assign shift_shl   = {shift_reg[BIN_W-2:0], 1'b0};

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load) state_next = SHIFT;
            SHIFT:   if (cnt_reg == CNT_W'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        ready = (state_reg == IDLE);
        busy  = (state_reg != IDLE);
    end

    // Conversion datapath next values
    always_comb begin
        shift_next    = shift_reg;
        scratch_next  = scratch_reg;
        cnt_next      = cnt_reg;
        ovf_flag_next = ovf_flag_reg;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    shift_next    = clamped;
                    scratch_next  = '0;
                    cnt_next      = CNT_W'(BIN_W);
                    ovf_flag_next = over_limit;
                end
            end
            SHIFT: begin
                shift_next   = shift_shl;
                scratch_next = scratch_shl;
                cnt_next     = cnt_reg - CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg    <= '0;
            scratch_reg  <= '0;
            cnt_reg      <= '0;
            ovf_flag_reg <= 1'b0;
        end else begin
            shift_reg    <= shift_next;
            scratch_reg  <= scratch_next;
            cnt_reg      <= cnt_next;
            ovf_flag_reg <= ovf_flag_next;
        end
    end

    // Snapshot outputs: only the DONE cycle updates them
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_reg   <= '0;
            seg_reg   <= seg_rst;
            ovf_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= (state_reg == DONE);
            if (state_reg == DONE) begin
                bcd_reg <= scratch_reg;
                seg_reg <= seg_dec;
                ovf_reg <= ovf_flag_reg;
            end
        end
    end

    assign bcd      = bcd_reg;
    assign seg      = seg_reg;
    assign overflow = ovf_reg;
    assign valid    = valid_reg;

endmodule

// File: tb/tb_count_bcd_decoder.sv
// Randomised self-checking bench for count_bcd_decoder; one instance with
// leading-zero blanking off and one with it on share all stimulus.
module tb_count_bcd_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_in = '0;
    logic        load = 1'b0;

    logic        ready, busy, valid, overflow;
    logic [15:0] bcd;
    logic [27:0] seg;
    logic        ready_lz, busy_lz, valid_lz, overflow_lz;
    logic [15:0] bcd_lz;
    logic [27:0] seg_lz;

    int checks   = 0;
    int failures = 0;
    logic busy_seen, ready_seen;

    localparam logic [6:0] SEG_TAB [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clk = ~clk;

    count_bcd_decoder #(.BIN_W(16), .DIGITS(4), .MAX_VAL(9999), .BLANK_LZ(0)) dut (
        .clk(clk), .rst(rst), .value_in(value_in), .load(load),
        .ready(ready), .busy(busy), .valid(valid), .overflow(overflow),
        .bcd(bcd), .seg(seg)
    );

    count_bcd_decoder #(.BIN_W(16), .DIGITS(4), .MAX_VAL(9999), .BLANK_LZ(1)) dut_lz (
        .clk(clk), .rst(rst), .value_in(value_in), .load(load),
        .ready(ready_lz), .busy(busy_lz), .valid(valid_lz), .overflow(overflow_lz),
        .bcd(bcd_lz), .seg(seg_lz)
    );

    // ---------------- reference model ----------------
    function automatic int clampv(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic logic [15:0] ref_bcd(input int v);
        int c;
        logic [15:0] r;
        c = clampv(v);
        r = '0;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((c / (10 ** i)) % 10);
        return r;
    endfunction

    function automatic logic [27:0] ref_seg(input int v, input bit lz);
        int c;
        logic [27:0] r;
        c = clampv(v);
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (lz && i > 0 && c < 10 ** i) r[7*i +: 7] = 7'h7F;
            else                            r[7*i +: 7] = SEG_TAB[(c / (10 ** i)) % 10];
        end
        return r;
    endfunction

    // Issue a one-cycle load and count edges from acceptance to valid (-1 on timeout)
    task automatic run_conv(input logic [15:0] v, output int edges);
        @(negedge clk);
        value_in = v;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load       = 1'b0;
        busy_seen  = busy;
        ready_seen = ready;
        edges = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                edges = k;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int pulses;
        rst  = 1'b1;
        load = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks += 6;
        if (ready !== 1'b1)     begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (valid !== 1'b0)     begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        if (bcd !== 16'h0000)   begin failures++; $display("FAIL reset_bcd got=%h exp=0000", bcd); end
        if (seg !== 28'h8102040) begin failures++; $display("FAIL reset_seg got=%h exp=8102040", seg); end
        if (seg_lz !== {7'h7F, 7'h7F, 7'h7F, 7'h40})
            begin failures++; $display("FAIL reset_seg_lz got=%h exp=%h", seg_lz, {7'h7F, 7'h7F, 7'h7F, 7'h40}); end
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL reset_idle_valid got=%0d exp=0", pulses); end
        $display("test_reset: idle outputs checked");
    endtask

    task automatic test_convert(input int v);
        int edges;
        logic [15:0] vv;
        vv = 16'(v);
        run_conv(vv, edges);
        checks += 8;
        if (busy_seen !== 1'b1)  begin failures++; $display("FAIL conv_busy v=%0d got=%b exp=1", v, busy_seen); end
        if (ready_seen !== 1'b0) begin failures++; $display("FAIL conv_ready_busy v=%0d got=%b exp=0", v, ready_seen); end
        if (edges != 17)         begin failures++; $display("FAIL conv_latency v=%0d got=%0d exp=17", v, edges); end
        if (bcd !== ref_bcd(v))  begin failures++; $display("FAIL conv_bcd v=%0d got=%h exp=%h", v, bcd, ref_bcd(v)); end
        if (seg !== ref_seg(v, 1'b0)) begin failures++; $display("FAIL conv_seg v=%0d got=%h exp=%h", v, seg, ref_seg(v, 1'b0)); end
        if (seg_lz !== ref_seg(v, 1'b1)) begin failures++; $display("FAIL conv_seg_lz v=%0d got=%h exp=%h", v, seg_lz, ref_seg(v, 1'b1)); end
        if (overflow !== (v > 9999)) begin failures++; $display("FAIL conv_overflow v=%0d got=%b exp=%b", v, overflow, v > 9999); end
        if (valid_lz !== 1'b1)   begin failures++; $display("FAIL conv_valid_lz v=%0d got=%b exp=1", v, valid_lz); end
        @(posedge clk);
        #1;
        checks += 2;
        if (valid !== 1'b0) begin failures++; $display("FAIL conv_valid_width v=%0d got=%b exp=0", v, valid); end
        if (ready !== 1'b1) begin failures++; $display("FAIL conv_ready_after v=%0d got=%b exp=1", v, ready); end
        $display("convert v=%0d edges=%0d bcd=%h seg=%h seg_lz=%h ovf=%b", v, edges, bcd, seg, seg_lz, overflow);
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) test_convert(int'($urandom_range(10000, 65535)));
            else                           test_convert(int'($urandom_range(0, 9999)));
        end
    endtask

    task automatic test_boundary();
        test_convert(9999);
        checks++;
        if (seg !== {7'h10, 7'h10, 7'h10, 7'h10}) begin failures++; $display("FAIL bound_seg_9999 got=%h", seg); end
        test_convert(10000);
        test_convert(65535);
        checks++;
        if (bcd !== 16'h9999) begin failures++; $display("FAIL bound_ffff got=%h exp=9999", bcd); end
        test_convert(0);
    endtask

    task automatic test_busy_ignore();
        int nvalid, first_edge;
        logic [15:0] first_bcd;
        @(negedge clk);
        value_in = 16'd7;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        nvalid = 0;
        first_edge = -1;
        first_bcd = '0;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                nvalid++;
                if (first_edge < 0) begin
                    first_edge = k;
                    first_bcd  = bcd;
                end
            end
            if (k == 4) begin
                value_in = 16'd42;
                load     = 1'b1;
            end else if (k == 5) begin
                load = 1'b0;
            end
        end
        checks += 3;
        if (nvalid != 1)           begin failures++; $display("FAIL busy_ignore_pulses got=%0d exp=1", nvalid); end
        if (first_edge != 17)      begin failures++; $display("FAIL busy_ignore_latency got=%0d exp=17", first_edge); end
        if (first_bcd !== 16'h0007) begin failures++; $display("FAIL busy_ignore_bcd got=%h exp=0007", first_bcd); end
        $display("busy_ignore: pulses=%0d edge=%0d bcd=%h", nvalid, first_edge, first_bcd);
    endtask

    task automatic test_back_to_back(input int n);
        int v, edges, exp_edges;
        v = int'($urandom_range(0, 9999));
        @(negedge clk);
        value_in = 16'(v);
        load     = 1'b1;
        @(posedge clk);
        #1;
        exp_edges = 17;
        for (int i = 0; i < n; i++) begin
            edges = -1;
            for (int k = 1; k <= 40; k++) begin
                @(posedge clk);
                #1;
                if (valid) begin
                    edges = k;
                    break;
                end
            end
            checks += 2;
            if (edges != exp_edges) begin failures++; $display("FAIL b2b_period i=%0d got=%0d exp=%0d", i, edges, exp_edges); end
            if (bcd !== ref_bcd(v)) begin failures++; $display("FAIL b2b_bcd i=%0d got=%h exp=%h", i, bcd, ref_bcd(v)); end
            $display("back_to_back i=%0d v=%0d edges=%0d bcd=%h", i, v, edges, bcd);
            v = int'($urandom_range(0, 9999));
            value_in = 16'(v);
            if (i == n - 1) load = 1'b0;
            exp_edges = 18;
        end
        repeat (20) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int pulses, edges;
        @(negedge clk);
        value_in = 16'd5678;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (valid) pulses++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (valid) pulses++;
        end
        checks += 5;
        if (pulses != 0)         begin failures++; $display("FAIL mid_reset_valid got=%0d exp=0", pulses); end
        if (bcd !== 16'h0000)    begin failures++; $display("FAIL mid_reset_bcd got=%h exp=0000", bcd); end
        if (seg !== 28'h8102040) begin failures++; $display("FAIL mid_reset_seg got=%h exp=8102040", seg); end
        if (ready !== 1'b1)      begin failures++; $display("FAIL mid_reset_ready got=%b exp=1", ready); end
        if (overflow !== 1'b0)   begin failures++; $display("FAIL mid_reset_ovf got=%b exp=0", overflow); end
        run_conv(16'd5678, edges);
        checks += 2;
        if (edges != 17)       begin failures++; $display("FAIL mid_reset_relatency got=%0d exp=17", edges); end
        if (bcd !== 16'h5678)  begin failures++; $display("FAIL mid_reset_rebcd got=%h exp=5678", bcd); end
        $display("reset_mid: pulses=%0d reconvert bcd=%h", pulses, bcd);
    endtask

    task automatic test_blank_lz();
        int edges;
        run_conv(16'd7, edges);
        checks++;
        if (seg_lz !== {7'h7F, 7'h7F, 7'h7F, 7'h78}) begin failures++; $display("FAIL lz_7 got=%h", seg_lz); end
        $display("blank_lz v=7 seg_lz=%h", seg_lz);
        run_conv(16'd0, edges);
        checks++;
        if (seg_lz !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin failures++; $display("FAIL lz_0 got=%h", seg_lz); end
        $display("blank_lz v=0 seg_lz=%h", seg_lz);
        run_conv(16'd1000, edges);
        checks++;
        if (seg_lz !== {7'h79, 7'h40, 7'h40, 7'h40}) begin failures++; $display("FAIL lz_1000 got=%h", seg_lz); end
        $display("blank_lz v=1000 seg_lz=%h", seg_lz);
    endtask

    initial begin
        test_reset();
        test_convert(1234);
        checks++;
        if (seg !== {7'h79, 7'h24, 7'h30, 7'h19}) begin failures++; $display("FAIL conv1234_seg got=%h", seg); end
        test_boundary();
        test_random(12);
        test_busy_ignore();
        test_back_to_back(4);
        test_reset_mid();
        test_blank_lz();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
